// File: rtl/ms53l_uart_tx.sv
// ms53l_uart_tx: rising-edge triggered 8N1 UART transmitter for the MS53L command path.
// Optional parity bit between data and stop is enabled by defining UART_TX_PARITY_EN.
module ms53l_uart_tx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_en,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       uart_txd
);
    localparam int BAUD_CNT = CLK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(BAUD_CNT);

    if (STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("ms53l_uart_tx: STOP_BITS must be 1 or 2 and PARITY_ODD 0 or 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          en_d_q, en_d_d;
    logic          txd_q, txd_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          en_rise, bit_end;

    assign en_rise  = tx_en & ~en_d_q;
    assign bit_end  = baud_cnt_q == CW'(BAUD_CNT - 1);
    assign uart_txd = txd_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            en_d_q     <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            en_d_q     <= en_d_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (en_rise) state_d = START;
            START:  if (bit_end) state_d = DATA;
`ifdef UART_TX_PARITY_EN
            DATA:   if (bit_end && bit_cnt_q == 3'd7) state_d = PARITY;
            PARITY: if (bit_end) state_d = STOP;
`else
            DATA:   if (bit_end && bit_cnt_q == 3'd7) state_d = STOP;
`endif
            STOP:   if (bit_end && bit_cnt_q == 3'(STOP_BITS - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the state being entered.
    always_comb begin
        en_d_d     = tx_en;
        shift_d    = (state_q == IDLE && en_rise) ? tx_data : shift_q;
        baud_cnt_d = (state_q == IDLE || bit_end) ? '0 : baud_cnt_q + 1'b1;
        bit_cnt_d  = (state_q == IDLE) ? 3'd0 :
                     ((state_q == DATA || state_q == STOP) && bit_end) ? bit_cnt_q + 3'd1 : bit_cnt_q;
`ifdef UART_TX_PARITY_EN
        txd_d      = (state_d == START)  ? 1'b0 :
                     (state_d == DATA)   ? shift_d[bit_cnt_d] :
                     (state_d == PARITY) ? (^shift_q) ^ PARITY_ODD[0] : 1'b1;
`else
        txd_d      = (state_d == START) ? 1'b0 :
                     (state_d == DATA)  ? shift_d[bit_cnt_d] : 1'b1;
`endif
        busy_d     = state_d != IDLE;
        done_d     = state_q == STOP && state_d == IDLE;
    end
endmodule
